// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: func3 encodings, LSU state type and
// the func3 legality helper used by the alignment logic.
`timescale 1ns/1ps
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_t;

  // Legal size/sign encodings; unsigned variants only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store data replication and byte enables,
// load byte/halfword extraction with extension, and access fault detection.
`timescale 1ns/1ps
module lsu_align
  import riscv_pkg::*;
(
  input  logic        is_read,
  input  logic        is_write,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);

  logic        misalign_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store lane replication and byte-enable generation.
  always_comb begin
    st_wdata = store_data;
    st_be    = 4'b0000;
    case (func3)
      F3_B: begin
        st_wdata = {4{store_data[7:0]}};
        st_be    = 4'b0001 << addr_lo;
      end
      F3_H: begin
        st_wdata = {2{store_data[15:0]}};
        st_be    = 4'b0011 << {addr_lo[1], 1'b0};
      end
      F3_W: begin
        st_wdata = store_data;
        st_be    = 4'b1111;
      end
      default: begin
        st_wdata = store_data;
        st_be    = 4'b0000;
      end
    endcase
  end

  // Fault: conflicting access type, illegal size, or unaligned address.
  always_comb begin
    misalign_s = 1'b0;
    case (func3)
      F3_H, F3_HU: misalign_s = addr_lo[0];
      F3_W:        misalign_s = (addr_lo != 2'b00);
      default:     misalign_s = 1'b0;
    endcase
    fault = (is_read & is_write) | ~f3_legal(func3, is_write) | misalign_s;
  end

  // Load lane select from the captured low address bits.
  always_comb begin
    ld_byte_s = 8'h00;
    case (ld_addr_lo)
      2'd0:    ld_byte_s = rdata[7:0];
      2'd1:    ld_byte_s = rdata[15:8];
      2'd2:    ld_byte_s = rdata[23:16];
      2'd3:    ld_byte_s = rdata[31:24];
      default: ld_byte_s = 8'h00;
    endcase
    if (ld_addr_lo[1]) begin
      ld_half_s = rdata[31:16];
    end else begin
      ld_half_s = rdata[15:0];
    end
  end

  // Sign or zero extension according to the captured func3.
  always_comb begin
    ld_data = 32'h0000_0000;
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      F3_BU:   ld_data = {24'h00_0000, ld_byte_s};
      F3_H:    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
      F3_HU:   ld_data = {16'h0000, ld_half_s};
      F3_W:    ld_data = rdata;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: IDLE/BUSY req/ack sequencer for the data port, ack
// timeout, fault pulses and the registered MEM/WB fields.
`timescale 1ns/1ps
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWrite_MEM_IN,
  input  logic        memRead_MEM_IN,
  input  logic        regWrite_MEM_IN,
  input  logic        memToRegWrite_MEM_IN,
  input  logic [2:0]  func3_MEM_IN,
  input  logic [31:0] aluOut_MEM_IN,
  input  logic [31:0] aluSrc2_MEM_IN,
  input  logic [4:0]  rd_MEM_IN,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_MEM_OUT,
  output logic        misaligned_MEM_OUT,
  output logic        busError_MEM_OUT,
  output logic        regWrite_WB_OUT,
  output logic        memToRegWrite_WB_OUT,
  output logic [31:0] readData_WB_OUT,
  output logic [31:0] aluOut_WB_OUT,
  output logic [4:0]  rd_WB_OUT
);

  // Last BUSY count value before the bus is declared dead (0 = never).
  localparam logic        TO_EN_C  = (ACK_TIMEOUT != 0);
  localparam logic [15:0] TO_LIM_C = 16'((ACK_TIMEOUT == 0) ? 0 : (ACK_TIMEOUT - 1));

  lsu_state_t  state_r;
  logic [15:0] cnt_r;

  logic        req_r, we_r;
  logic [31:0] addr_r, wdata_r, alu_r;
  logic [3:0]  be_r;
  logic [2:0]  f3_r;
  logic [4:0]  rd_r;
  logic        rw_r, m2r_r;

  logic        wb_rw_r, wb_m2r_r, mis_r, buserr_r;
  logic [31:0] wb_rdata_r, wb_alu_r;
  logic [4:0]  wb_rd_r;

  logic        access_s, fault_s, timeout_s, stall_s;
  logic [31:0] st_wdata_s, ld_data_s;
  logic [3:0]  st_be_s;

  assign access_s = memRead_MEM_IN | memWrite_MEM_IN;

  lsu_align u_align (
    .is_read    (memRead_MEM_IN),
    .is_write   (memWrite_MEM_IN),
    .func3      (func3_MEM_IN),
    .addr_lo    (aluOut_MEM_IN[1:0]),
    .store_data (aluSrc2_MEM_IN),
    .ld_func3   (f3_r),
    .ld_addr_lo (alu_r[1:0]),
    .rdata      (dmem_rdata),
    .fault      (fault_s),
    .st_wdata   (st_wdata_s),
    .st_be      (st_be_s),
    .ld_data    (ld_data_s)
  );

  // Timeout fires on the last permitted BUSY cycle; a same-cycle ack wins.
  always_comb begin
    if ((state_r == LSU_BUSY) && TO_EN_C && (cnt_r == TO_LIM_C) && !dmem_ack) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Stall while a valid access is being issued or is still outstanding.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      LSU_IDLE: begin
        if (access_s && !fault_s) stall_s = 1'b1;
        else                      stall_s = 1'b0;
      end
      LSU_BUSY: begin
        if (dmem_ack || timeout_s) stall_s = 1'b0;
        else                       stall_s = 1'b1;
      end
      default: stall_s = 1'b0;
    endcase
  end

  // Sequencer, transaction capture, timeout counter and MEM/WB registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= LSU_IDLE;
      cnt_r      <= 16'd0;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= 32'h0;
      wdata_r    <= 32'h0;
      alu_r      <= 32'h0;
      be_r       <= 4'b0000;
      f3_r       <= 3'b000;
      rd_r       <= 5'd0;
      rw_r       <= 1'b0;
      m2r_r      <= 1'b0;
      wb_rw_r    <= 1'b0;
      wb_m2r_r   <= 1'b0;
      wb_rdata_r <= 32'h0;
      wb_alu_r   <= 32'h0;
      wb_rd_r    <= 5'd0;
      mis_r      <= 1'b0;
      buserr_r   <= 1'b0;
    end else begin
      mis_r    <= 1'b0;
      buserr_r <= 1'b0;
      case (state_r)
        LSU_IDLE: begin
          if (!access_s) begin
            wb_rw_r    <= regWrite_MEM_IN;
            wb_m2r_r   <= memToRegWrite_MEM_IN;
            wb_rdata_r <= 32'h0;
            wb_alu_r   <= aluOut_MEM_IN;
            wb_rd_r    <= rd_MEM_IN;
          end else if (fault_s) begin
            wb_rw_r    <= 1'b0;
            wb_m2r_r   <= 1'b0;
            wb_rdata_r <= 32'h0;
            wb_alu_r   <= 32'h0;
            wb_rd_r    <= 5'd0;
            mis_r      <= 1'b1;
          end else begin
            state_r    <= LSU_BUSY;
            cnt_r      <= 16'd0;
            req_r      <= 1'b1;
            we_r       <= memWrite_MEM_IN;
            addr_r     <= {aluOut_MEM_IN[31:2], 2'b00};
            wdata_r    <= st_wdata_s;
            be_r       <= memWrite_MEM_IN ? st_be_s : 4'b0000;
            alu_r      <= aluOut_MEM_IN;
            f3_r       <= func3_MEM_IN;
            rd_r       <= rd_MEM_IN;
            rw_r       <= regWrite_MEM_IN;
            m2r_r      <= memToRegWrite_MEM_IN;
            wb_rw_r    <= 1'b0;
            wb_m2r_r   <= 1'b0;
            wb_rdata_r <= 32'h0;
            wb_alu_r   <= 32'h0;
            wb_rd_r    <= 5'd0;
          end
        end
        LSU_BUSY: begin
          if (dmem_ack) begin
            state_r    <= LSU_IDLE;
            req_r      <= 1'b0;
            wb_rw_r    <= rw_r;
            wb_m2r_r   <= m2r_r;
            wb_rdata_r <= we_r ? 32'h0 : ld_data_s;
            wb_alu_r   <= alu_r;
            wb_rd_r    <= rd_r;
          end else if (timeout_s) begin
            state_r    <= LSU_IDLE;
            req_r      <= 1'b0;
            wb_rw_r    <= 1'b0;
            wb_m2r_r   <= 1'b0;
            wb_rdata_r <= 32'h0;
            wb_alu_r   <= 32'h0;
            wb_rd_r    <= 5'd0;
            buserr_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= LSU_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req             = req_r;
  assign dmem_we              = we_r;
  assign dmem_addr            = addr_r;
  assign dmem_wdata           = wdata_r;
  assign dmem_be              = be_r;
  assign stall_MEM_OUT        = stall_s;
  assign misaligned_MEM_OUT   = mis_r;
  assign busError_MEM_OUT     = buserr_r;
  assign regWrite_WB_OUT      = wb_rw_r;
  assign memToRegWrite_WB_OUT = wb_m2r_r;
  assign readData_WB_OUT      = wb_rdata_r;
  assign aluOut_WB_OUT        = wb_alu_r;
  assign rd_WB_OUT            = wb_rd_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (ACK_TIMEOUT = 4).
`timescale 1ns/1ps
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memWrite_MEM_IN, memRead_MEM_IN, regWrite_MEM_IN, memToRegWrite_MEM_IN;
  logic [2:0]  func3_MEM_IN;
  logic [31:0] aluOut_MEM_IN, aluSrc2_MEM_IN;
  logic [4:0]  rd_MEM_IN;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        stall_MEM_OUT, misaligned_MEM_OUT, busError_MEM_OUT;
  logic        regWrite_WB_OUT, memToRegWrite_WB_OUT;
  logic [31:0] readData_WB_OUT, aluOut_WB_OUT;
  logic [4:0]  rd_WB_OUT;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .memWrite_MEM_IN(memWrite_MEM_IN), .memRead_MEM_IN(memRead_MEM_IN),
    .regWrite_MEM_IN(regWrite_MEM_IN), .memToRegWrite_MEM_IN(memToRegWrite_MEM_IN),
    .func3_MEM_IN(func3_MEM_IN), .aluOut_MEM_IN(aluOut_MEM_IN),
    .aluSrc2_MEM_IN(aluSrc2_MEM_IN), .rd_MEM_IN(rd_MEM_IN),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_MEM_OUT(stall_MEM_OUT),
    .misaligned_MEM_OUT(misaligned_MEM_OUT), .busError_MEM_OUT(busError_MEM_OUT),
    .regWrite_WB_OUT(regWrite_WB_OUT), .memToRegWrite_WB_OUT(memToRegWrite_WB_OUT),
    .readData_WB_OUT(readData_WB_OUT), .aluOut_WB_OUT(aluOut_WB_OUT),
    .rd_WB_OUT(rd_WB_OUT)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    memWrite_MEM_IN = 1'b0; memRead_MEM_IN = 1'b0;
    regWrite_MEM_IN = 1'b0; memToRegWrite_MEM_IN = 1'b0;
    func3_MEM_IN = 3'b000; aluOut_MEM_IN = 32'h0; aluSrc2_MEM_IN = 32'h0;
    rd_MEM_IN = 5'd0;
  endtask

  task automatic present(input logic rd_en, input logic wr_en, input logic rw,
                         input logic m2r, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd);
    memRead_MEM_IN = rd_en; memWrite_MEM_IN = wr_en;
    regWrite_MEM_IN = rw; memToRegWrite_MEM_IN = m2r;
    func3_MEM_IN = f3; aluOut_MEM_IN = addr; aluSrc2_MEM_IN = sd; rd_MEM_IN = rd;
  endtask

  task automatic test_reset();
    idle_inputs(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall_MEM_OUT,
         misaligned_MEM_OUT, busError_MEM_OUT, regWrite_WB_OUT, memToRegWrite_WB_OUT,
         readData_WB_OUT, aluOut_WB_OUT, rd_WB_OUT} !== 144'h0) begin
      errors++; $display("FAIL reset_outputs: outputs not all zero (req=%b addr=%h wb_rw=%b)",
                         dmem_req, dmem_addr, regWrite_WB_OUT);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_non_mem();
    @(posedge clk); #1;
    present(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5);
    #1;
    checks++;
    if (stall_MEM_OUT !== 1'b0) begin errors++; $display("FAIL nonmem_stall: got %b want 0", stall_MEM_OUT); end
    @(posedge clk); #1;
    checks++;
    if ({aluOut_WB_OUT, rd_WB_OUT, regWrite_WB_OUT, readData_WB_OUT} !== {32'h1234, 5'd5, 1'b1, 32'h0}) begin
      errors++; $display("FAIL nonmem_wb: alu=%h rd=%0d rw=%b rdata=%h want 1234/5/1/0",
                         aluOut_WB_OUT, rd_WB_OUT, regWrite_WB_OUT, readData_WB_OUT);
    end
    idle_inputs();
  endtask

  task automatic test_store_byte();
    @(posedge clk); #1;
    present(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h103, 32'h0000_00AB, 5'd0);
    #1;
    checks++;
    if ({stall_MEM_OUT, dmem_req} !== 2'b10) begin errors++; $display("FAIL sb_issue: stall=%b req=%b want 1/0", stall_MEM_OUT, dmem_req); end
    @(posedge clk); #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall_MEM_OUT} !==
        {1'b1, 1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB, 1'b1}) begin
      errors++; $display("FAIL sb_bus: req=%b we=%b addr=%h be=%b wdata=%h stall=%b want 1/1/100/1000/abababab/1",
                         dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall_MEM_OUT);
    end
    dmem_ack = 1'b1; #1;
    checks++;
    if (stall_MEM_OUT !== 1'b0) begin errors++; $display("FAIL sb_ack_stall: got %b want 0", stall_MEM_OUT); end
    @(posedge clk); #1;
    dmem_ack = 1'b0; idle_inputs();
    checks++;
    if ({dmem_req, readData_WB_OUT, aluOut_WB_OUT} !== {1'b0, 32'h0, 32'h103}) begin
      errors++; $display("FAIL sb_done: req=%b rdata=%h alu=%h want 0/0/103", dmem_req, readData_WB_OUT, aluOut_WB_OUT);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] adr [6] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h104, 32'h101};
    logic [31:0] rdw [6] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000,
                             32'hDEAD_BEEF, 32'h0000_7F00};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                             32'hDEAD_BEEF, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      present(1'b1, 1'b0, 1'b1, 1'b1, f3s[i], adr[i], 32'h0, 5'd7);
      @(posedge clk); #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, {adr[i][31:2], 2'b00}}) begin
        errors++; $display("FAIL load%0d_bus: req=%b we=%b addr=%h", i, dmem_req, dmem_we, dmem_addr);
      end
      dmem_rdata = rdw[i]; dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h0; idle_inputs();
      checks++;
      if ({readData_WB_OUT, regWrite_WB_OUT, memToRegWrite_WB_OUT, rd_WB_OUT} !== {exp[i], 1'b1, 1'b1, 5'd7}) begin
        errors++; $display("FAIL load%0d_wb: rdata=%h rw=%b m2r=%b rd=%0d want %h/1/1/7",
                           i, readData_WB_OUT, regWrite_WB_OUT, memToRegWrite_WB_OUT, rd_WB_OUT, exp[i]);
      end
    end
  endtask

  task automatic test_faults();
    logic        rds [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        wrs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [5] = '{3'b010, 3'b010, 3'b011, 3'b100, 3'b001};
    logic [31:0] adr [5] = '{32'h101, 32'h100, 32'h100, 32'h100, 32'h201};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      present(rds[i], wrs[i], 1'b1, rds[i], f3s[i], adr[i], 32'h55, 5'd9);
      #1;
      checks++;
      if ({stall_MEM_OUT, dmem_req} !== 2'b00) begin
        errors++; $display("FAIL fault%0d_issue: stall=%b req=%b want 0/0", i, stall_MEM_OUT, dmem_req);
      end
      @(posedge clk); #1;
      idle_inputs();
      checks++;
      if ({misaligned_MEM_OUT, regWrite_WB_OUT, memToRegWrite_WB_OUT, dmem_req} !== 4'b1000) begin
        errors++; $display("FAIL fault%0d_pulse: mis=%b rw=%b m2r=%b req=%b want 1/0/0/0",
                           i, misaligned_MEM_OUT, regWrite_WB_OUT, memToRegWrite_WB_OUT, dmem_req);
      end
      @(posedge clk); #1;
      checks++;
      if (misaligned_MEM_OUT !== 1'b0) begin errors++; $display("FAIL fault%0d_clear: mis=%b want 0", i, misaligned_MEM_OUT); end
    end
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    int be_cnt  = 0;
    @(posedge clk); #1;
    present(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 5'd3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (dmem_req) begin
        req_cnt++;
        if (!stall_MEM_OUT) idle_inputs();
      end
      if (busError_MEM_OUT) begin
        be_cnt++;
        checks++;
        if ({regWrite_WB_OUT, memToRegWrite_WB_OUT, dmem_req} !== 3'b000) begin
          errors++; $display("FAIL timeout_bubble: rw=%b m2r=%b req=%b want 0/0/0",
                             regWrite_WB_OUT, memToRegWrite_WB_OUT, dmem_req);
        end
      end
    end
    idle_inputs();
    checks++;
    if (req_cnt != 4) begin errors++; $display("FAIL timeout_req_cycles: got %0d want 4", req_cnt); end
    checks++;
    if (be_cnt != 1) begin errors++; $display("FAIL timeout_buserr_pulses: got %0d want 1", be_cnt); end
    checks++;
    if ({dmem_req, stall_MEM_OUT} !== 2'b00) begin errors++; $display("FAIL timeout_idle: req=%b stall=%b want 0/0", dmem_req, stall_MEM_OUT); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    present(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 5'd1);
    @(posedge clk); #1;
    dmem_rdata = 32'h1111_1111; dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    present(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h14, 32'h0, 5'd2);
    #1;
    checks++;
    if ({dmem_req, stall_MEM_OUT, readData_WB_OUT, rd_WB_OUT} !== {1'b0, 1'b1, 32'h1111_1111, 5'd1}) begin
      errors++; $display("FAIL b2b_gap: req=%b stall=%b rdata=%h rd=%0d want 0/1/11111111/1",
                         dmem_req, stall_MEM_OUT, readData_WB_OUT, rd_WB_OUT);
    end
    @(posedge clk); #1;
    checks++;
    if ({dmem_req, dmem_addr} !== {1'b1, 32'h14}) begin errors++; $display("FAIL b2b_second_req: req=%b addr=%h want 1/14", dmem_req, dmem_addr); end
    dmem_rdata = 32'h2222_2222; dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0; idle_inputs();
    checks++;
    if ({readData_WB_OUT, rd_WB_OUT} !== {32'h2222_2222, 5'd2}) begin
      errors++; $display("FAIL b2b_second_wb: rdata=%h rd=%0d want 22222222/2", readData_WB_OUT, rd_WB_OUT);
    end
  endtask

  task automatic test_rst_busy();
    @(posedge clk); #1;
    present(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 5'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: req=%b want 1", dmem_req); end
    idle_inputs();
    rst = 1'b1; #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, stall_MEM_OUT, regWrite_WB_OUT, readData_WB_OUT, rd_WB_OUT} !== 76'h0) begin
      errors++; $display("FAIL rst_async: req=%b addr=%h be=%b stall=%b rw=%b want all 0",
                         dmem_req, dmem_addr, dmem_be, stall_MEM_OUT, regWrite_WB_OUT);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rdata = 32'hFFFF_FFFF; dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    checks++;
    if ({regWrite_WB_OUT, memToRegWrite_WB_OUT, readData_WB_OUT, dmem_req} !== 35'h0) begin
      errors++; $display("FAIL rst_late_ack: rw=%b m2r=%b rdata=%h req=%b want 0/0/0/0",
                         regWrite_WB_OUT, memToRegWrite_WB_OUT, readData_WB_OUT, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_store_byte();
    test_loads();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_rst_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
